// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- shown to decode whenever no real instruction is available.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO used both for {pc,inst} words headed to decode and
// for the PCs of requests still in flight to instruction memory.
// DEPTH must be a power of two, >= 2. Flush wins over push in the same cycle.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; flush empties the FIFO regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory under a credit rule that guarantees every response a buffer slot,
// and hands {inst, inst_pc} to decode. Redirects flush everything and drop
// responses still owed for requests issued before the redirect.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   FETCH_BOOT  | one idle cycle after reset, no requests
//   FETCH_RUN   | issuing requests as credits allow
//   FETCH_DRAIN | waiting out stale responses after a redirect, no requests
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int QW = $clog2(MAX_OUTST) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            redirect_act;
  logic            credit_ok;
  logic            req_fire;
  logic            buf_push;
  logic            buf_pop;
  logic            buf_full;
  logic            buf_empty;
  logic [CW-1:0]   buf_count;
  logic [2*XLEN-1:0] buf_head;
  logic [XLEN-1:0] pcq_head;
  logic            pcq_full;
  logic            pcq_empty;
  logic [QW-1:0]   pcq_count;
  logic            unused_status;

  // Redirects are meaningless before the first fetch has been issued.
  assign redirect_act = redirect && (state_q != FETCH_BOOT);

  // Count buffered words and words still owed by memory together so a
  // response can never find the buffer full.
  assign credit_ok = (({1'b0, outst_q} + {1'b0, buf_count}) < (CW+1)'(BUF_DEPTH))
                     && (outst_q < CW'(MAX_OUTST));

  assign imem_req_valid = (state_q == FETCH_RUN) && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to pre-redirect requests are discarded; a redirect in the
  // same cycle also discards via the buffer's flush priority.
  assign buf_push = imem_rsp_valid && (drop_q == '0);

  // The head is killed combinationally on redirect so a wrong-path word is
  // never consumed.
  assign inst_valid = !buf_empty && !redirect_act;
  assign buf_pop    = inst_valid && inst_ready;
  assign inst       = inst_valid ? buf_head[XLEN-1:0] : XLEN'(INST_NOP);
  assign inst_pc    = inst_valid ? buf_head[2*XLEN-1:XLEN] : fetch_pc_q;

  assign unused_status = ^{buf_full, pcq_full, pcq_empty, pcq_count, redirect_pc[1:0]};

  fetch_buffer #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTST)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (imem_rsp_valid),
    .flush     (redirect_act),
    .head_data (pcq_head),
    .full      (pcq_full),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  fetch_buffer #(
    .WIDTH (2*XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_inst_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data ({pcq_head, imem_rsp_data}),
    .pop       (buf_pop),
    .flush     (redirect_act),
    .head_data (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Next state, PC, in-flight count and drop count.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      outst_d    = outst_d + CW'(1);
    end
    if (imem_rsp_valid) begin
      outst_d = outst_d - CW'(1);
      if (drop_q != '0) drop_d = drop_q - CW'(1);
    end

    case (state_q)
      FETCH_BOOT:  state_d = FETCH_RUN;
      FETCH_RUN:   state_d = FETCH_RUN;
      FETCH_DRAIN: if (drop_d == '0) state_d = FETCH_RUN;
      default:     state_d = FETCH_BOOT;
    endcase

    // Everything still owed after this cycle's updates belongs to the old path,
    // including a request accepted in the redirect cycle itself.
    if (redirect_act) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = outst_d;
      state_d    = (outst_d != '0) ? FETCH_DRAIN : FETCH_RUN;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_BOOT;
      fetch_pc_q <= XLEN'(RESET_PC);
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an instruction-memory model with configurable latency,
// a scoreboard of expected {pc, inst} in program order, a per-cycle vector
// table for the start-up timing, and hand sequences for redirect corners.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          BUF_DEPTH = 2;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RST_PC_A  = 32'h0000_0000;
  localparam logic [31:0] RST_PC_B  = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst_n;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        req_valid_a, inst_valid_a, req_valid_b, inst_valid_b;
  logic [31:0] req_addr_a, inst_a, inst_pc_a, req_addr_b, inst_b, inst_pc_b;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC_A), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTST(MAX_OUTST)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_a),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid_a), .inst_ready(inst_ready), .inst(inst_a), .inst_pc(inst_pc_a),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  // Second instance starting near the top of the address space to see the PC wrap.
  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC_B), .BUF_DEPTH(BUF_DEPTH), .MAX_OUTST(MAX_OUTST)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_b),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid_b), .inst_ready(inst_ready), .inst(inst_b), .inst_pc(inst_pc_b),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct {
    logic ir; logic rv; logic [31:0] ra; logic [31:0] ra_b; logic iv; logic [31:0] ipc;
  } vec_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          cyc = 0;
  int          since_rst = 0;
  int          mem_lat = 1;
  int          outst_m = 0;
  int          drop_m = 0;
  int          req_cnt = 0;
  logic [31:0] exp_pc;
  logic        obs_rv, obs_iv, obs_rv_b, obs_iv_b;
  logic [31:0] obs_ra, obs_inst, obs_ipc, obs_ra_b;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Async reset: assert, check outputs immediately, hold two cycles, release on a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #1;
    chk("rst_req_valid", req_valid_a, 0);
    chk("rst_inst_valid", inst_valid_a, 0);
    chk("rst_inst_nop", inst_a, INST_NOP);
    chk("rst_inst_pc", inst_pc_a, RST_PC_A);
    chk("rst_inst_pc_wrap", inst_pc_b, RST_PC_B);
    chk("rst_inst_nop_wrap", inst_b, INST_NOP);
    mem_q.delete(); exp_q.delete();
    outst_m = 0; drop_m = 0; req_cnt = 0; exp_pc = RST_PC_A;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    since_rst = 0;
  endtask

  // One clock cycle, entered just after a negedge: drive, settle, score, advance.
  task automatic step(input logic rr, input logic ir, input logic rd, input logic [31:0] rpc);
    mreq_t m;
    exp_t  e;
    imem_req_ready = rr; inst_ready = ir; redirect = rd; redirect_pc = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(m.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    obs_rv = req_valid_a; obs_ra = req_addr_a; obs_iv = inst_valid_a;
    obs_inst = inst_a; obs_ipc = inst_pc_a;
    obs_rv_b = req_valid_b; obs_ra_b = req_addr_b; obs_iv_b = inst_valid_b;

    if (drop_m > 0) chk("no_req_in_drain", obs_rv, 0);
    if (outst_m >= MAX_OUTST || exp_q.size() >= BUF_DEPTH) chk("credit_stall", obs_rv, 0);
    if (obs_rv && rr) begin
      chk("req_addr", obs_ra, exp_pc);
      e.pc = exp_pc; e.data = memf(exp_pc);
      exp_q.push_back(e);
      m.addr = obs_ra; m.due = cyc + mem_lat;
      mem_q.push_back(m);
      exp_pc = exp_pc + 32'd4;
      outst_m++; req_cnt++;
    end

    if (rd && since_rst > 0) chk("kill_on_redirect", obs_iv, 0);
    if (!obs_iv) chk("nop_when_idle", obs_inst, INST_NOP);
    else if (exp_q.size() == 0) chk("stale_word", obs_iv, 0);
    else begin
      chk("inst_pc", obs_ipc, exp_q[0].pc);
      chk("inst_data", obs_inst, exp_q[0].data);
      if (ir) void'(exp_q.pop_front());
    end

    if (imem_rsp_valid) begin
      outst_m--;
      if (drop_m > 0) drop_m--;
    end
    if (rd && since_rst > 0) begin
      exp_q.delete();
      exp_pc = rpc & ~32'd3;
      drop_m = outst_m;
    end
    cyc++; since_rst++;
    @(negedge clk);
  endtask

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bit got;

    // Start-up timing, memory latency 1, decoder always ready.
    tbl[0] = '{ir:1, rv:0, ra:32'h0,  ra_b:32'h0,         iv:0, ipc:32'h0};
    tbl[1] = '{ir:1, rv:1, ra:32'h0,  ra_b:32'hFFFF_FFF8, iv:0, ipc:32'h0};
    tbl[2] = '{ir:1, rv:1, ra:32'h4,  ra_b:32'hFFFF_FFFC, iv:0, ipc:32'h0};
    tbl[3] = '{ir:1, rv:0, ra:32'h0,  ra_b:32'h0,         iv:1, ipc:32'h0};
    tbl[4] = '{ir:1, rv:1, ra:32'h8,  ra_b:32'h0000_0000, iv:1, ipc:32'h4};
    tbl[5] = '{ir:1, rv:1, ra:32'hC,  ra_b:32'h0000_0004, iv:0, ipc:32'h0};
    tbl[6] = '{ir:1, rv:0, ra:32'h0,  ra_b:32'h0,         iv:1, ipc:32'h8};
    tbl[7] = '{ir:1, rv:1, ra:32'h10, ra_b:32'h0000_0008, iv:1, ipc:32'hC};

    rst_n = 1'b1;
    imem_req_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #2;

    // Streaming from reset, plus wrap of the second instance.
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].ir, 1'b0, 32'h0);
      chk($sformatf("t1_req_valid[%0d]", i), obs_rv, tbl[i].rv);
      chk($sformatf("t1_req_valid_wrap[%0d]", i), obs_rv_b, tbl[i].rv);
      chk($sformatf("t1_inst_valid[%0d]", i), obs_iv, tbl[i].iv);
      chk($sformatf("t1_inst_valid_wrap[%0d]", i), obs_iv_b, tbl[i].iv);
      if (tbl[i].rv) begin
        chk($sformatf("t1_req_addr[%0d]", i), obs_ra, tbl[i].ra);
        chk($sformatf("t1_req_addr_wrap[%0d]", i), obs_ra_b, tbl[i].ra_b);
      end
      if (tbl[i].iv) chk($sformatf("t1_inst_pc[%0d]", i), obs_ipc, tbl[i].ipc);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Decoder stalled: exactly two requests, then resume.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("t2_req_count", req_cnt, 2);
    chk("t2_req_held", obs_rv, 0);
    chk("t2_head_valid", obs_iv, 1);
    chk("t2_head_pc", obs_ipc, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t2_resumed", req_cnt > 2, 1);

    // Redirect with two requests in flight.
    mem_lat = 3;
    do_reset();
    for (int i = 0; i < 20 && outst_m < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t3_two_in_flight", outst_m, 2);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      got = obs_iv;
    end
    chk("t3_got_inst", got, 1);
    chk("t3_first_pc", obs_ipc, 32'h100);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coincident with a request handshake and a response.
    mem_lat = 1;
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    chk("t4_req_same_cycle", obs_rv, 1);
    chk("t4_req_addr_same_cycle", obs_ra, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_drain_no_req", obs_rv, 0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t4_resume_req", obs_rv, 1);
    chk("t4_resume_addr", obs_ra, 32'h40);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      got = obs_iv;
    end
    chk("t4_got_inst", got, 1);
    chk("t4_first_pc", obs_ipc, 32'h40);

    // Redirect ignored in boot, misaligned target, reset in the middle of a drain.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'h500);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_boot_redirect_ignored", obs_ra, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h203);
    base = req_cnt;
    for (int i = 0; i < 20 && req_cnt == base; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_req_after_redirect", req_cnt > base, 1);
    chk("t6_masked_addr", obs_ra, 32'h200);
    mem_lat = 3;
    for (int i = 0; i < 20 && outst_m < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_two_in_flight", outst_m, 2);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_in_drain_no_req", obs_rv, 0);
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_restart_count", req_cnt >= 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
